// File: rtl/tmds_encoder_dvi.sv
// Purpose: DVI 1.0 TMDS encoder for one 8-bit colour channel (build option: TMDS_ENCODER_PIPELINE_EN).
// Latency: 1 clk_pix cycle by default, 2 cycles with TMDS_ENCODER_PIPELINE_EN defined.
// Backpressure: none; accepts and emits one symbol every cycle, never stalls.
module tmds_encoder_dvi (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       de,
    input  logic [7:0] din,
    input  logic [1:0] ctrl,
    output logic [9:0] tmds
);

    // Control-period tokens, indexed by {C1,C0}
    localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

    // Stage 1 result (transition-minimised word, q_m[8] = 1 means XOR was used)
    logic [8:0] s1_qm;

    // Stage 2 inputs: either straight from stage 1 or from the mid-pipe registers
    logic [8:0] s2_qm;
    logic       s2_de;
    logic [1:0] s2_ctrl;

    // Output and running disparity registers
    logic [9:0]        tmds_q, tmds_d;
    logic signed [4:0] cnt_q,  cnt_d;

    // Stage 1: pick XOR/XNOR chain by ones count so the word has few transitions
    always_comb begin
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] qm;
        n1d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + {3'b000, din[i]};
        end
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !din[0]);
        qm    = 9'd0;
        qm[0] = din[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ din[i]) : (qm[i-1] ^ din[i]);
        end
        qm[8] = ~use_xnor;
        s1_qm = qm;
    end

`ifdef TMDS_ENCODER_PIPELINE_EN
    // Mid-pipe registers keep de/ctrl aligned with the stage-1 word
    logic [8:0] qm_q,   qm_d;
    logic       de_q,   de_d;
    logic [1:0] ctrl_q, ctrl_d;

    // Next state for the mid-pipe registers is simply the current stage-1 view
    always_comb begin
        qm_d   = s1_qm;
        de_d   = de;
        ctrl_d = ctrl;
    end

    // Mid-pipe registers; reset leaves a control-00 period in flight
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            qm_q   <= 9'd0;
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
        end else begin
            qm_q   <= qm_d;
            de_q   <= de_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign s2_qm   = qm_q;
    assign s2_de   = de_q;
    assign s2_ctrl = ctrl_q;
`else
    assign s2_qm   = s1_qm;
    assign s2_de   = de;
    assign s2_ctrl = ctrl;
`endif

    // Stage 2: DC balance against the running disparity, or emit a control token
    always_comb begin
        logic [3:0]        n1;
        logic [3:0]        n0;
        logic signed [4:0] diff;      // N1 - N0 of q_m[7:0], range -8..+8
        logic signed [4:0] two_q8;    // 2 * q_m[8]
        logic signed [4:0] two_nq8;   // 2 * ~q_m[8]
        logic              q8;
        logic              cnt_pos;
        logic              cnt_neg;

        n1 = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, s2_qm[i]};
        end
        n0      = 4'd8 - n1;
        diff    = $signed({1'b0, n1}) - $signed({1'b0, n0});
        q8      = s2_qm[8];
        two_q8  = q8 ? 5'sd2 : 5'sd0;
        two_nq8 = q8 ? 5'sd0 : 5'sd2;
        cnt_neg = cnt_q[4];
        cnt_pos = !cnt_q[4] && (cnt_q != 5'sd0);

        tmds_d = TOKEN_C00;
        cnt_d  = 5'sd0;

        if (!s2_de) begin
            // Control period: disparity restarts from zero on the next data period
            cnt_d = 5'sd0;
            case (s2_ctrl)
                2'b00:   tmds_d = TOKEN_C00;
                2'b01:   tmds_d = TOKEN_C01;
                2'b10:   tmds_d = TOKEN_C10;
                default: tmds_d = TOKEN_C11;
            endcase
        end else if ((cnt_q == 5'sd0) || (n1 == n0)) begin
            // Balanced word or no history: use q_m[8] to decide inversion
            tmds_d = {~q8, q8, (q8 ? s2_qm[7:0] : ~s2_qm[7:0])};
            cnt_d  = q8 ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
            // Word would push disparity further the same way: send it inverted
            tmds_d = {1'b1, q8, ~s2_qm[7:0]};
            cnt_d  = cnt_q + two_q8 - diff;
        end else begin
            // Word pulls disparity back toward zero: send it as is
            tmds_d = {1'b0, q8, s2_qm[7:0]};
            cnt_d  = cnt_q + diff - two_nq8;
        end
    end

    // Output symbol and running disparity; reset emits control token 00
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            tmds_q <= TOKEN_C00;
            cnt_q  <= 5'sd0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Bench for tmds_encoder_dvi: directed DVI vectors plus a long random run
// against a reference encoder, with a latency-aware scoreboard.
module tb_tmds_encoder_dvi;

`ifdef TMDS_ENCODER_PIPELINE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk_pix = 1'b0;
    logic       rst_pix;
    logic       de;
    logic [7:0] din;
    logic [1:0] ctrl;
    logic [9:0] tmds;

    typedef struct packed {
        logic [9:0] sym;
        int         cnt;
    } exp_t;

    exp_t  sb[$];
    int    m_cnt = 0;
    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    tmds_encoder_dvi dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .de      (de),
        .din     (din),
        .ctrl    (ctrl),
        .tmds    (tmds)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s_%s got=%0d (0x%0h) want=%0d (0x%0h) t=%0t",
                     phase, tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference DVI 1.0 encoder written straight from the algorithm description
    function automatic void ref_enc(input logic de_i, input logic [7:0] d,
                                    input logic [1:0] c, input int cnt_in,
                                    output logic [9:0] sym, output int cnt_out);
        int         n1d;
        int         n1;
        int         n0;
        bit         xn;
        logic [8:0] qm;
        n1d   = $countones(d);
        xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = xn ? 1'b0 : 1'b1;
        n1    = $countones(qm[7:0]);
        n0    = 8 - n1;
        if (!de_i) begin
            cnt_out = 0;
            case (c)
                2'b00:   sym = 10'b1101010100;
                2'b01:   sym = 10'b0010101011;
                2'b10:   sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
        end else if (cnt_in == 0 || n1 == n0) begin
            sym = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
            cnt_out = qm[8] ? cnt_in + (n1 - n0) : cnt_in + (n0 - n1);
        end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            cnt_out = cnt_in + (qm[8] ? 2 : 0) + (n0 - n1);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            cnt_out = cnt_in + (n1 - n0) - (qm[8] ? 0 : 2);
        end
    endfunction

    // One clock: drive inputs, push the expectation, compare whatever is due now
    task automatic step(input logic r, input logic d_e, input logic [7:0] d,
                        input logic [1:0] c, input bit use_exp,
                        input logic [9:0] e_sym, input int e_cnt);
        logic [9:0] s;
        int         nc;
        exp_t       e;
        int         obs_cnt;
        rst_pix = r;
        de      = d_e;
        din     = d;
        ctrl    = c;
        @(posedge clk_pix);
        #1;
        if (r) begin
            // In-flight symbols are discarded; the pipe refills with control-00
            m_cnt = 0;
            sb.delete();
            for (int i = 0; i < LAT; i++) sb.push_back('{sym: 10'h354, cnt: 0});
        end else begin
            ref_enc(d_e, d, c, m_cnt, s, nc);
            m_cnt = nc;
            if (use_exp) sb.push_back('{sym: e_sym, cnt: e_cnt});
            else         sb.push_back('{sym: s, cnt: nc});
        end
        if (sb.size() >= LAT) begin
            e = sb.pop_front();
            obs_cnt = int'($signed(dut.cnt_q));
            chk("tmds", int'(tmds), int'(e.sym));
            chk("cnt", obs_cnt, e.cnt);
            chk("cnt_bound", int'(obs_cnt >= -8 && obs_cnt <= 8), 1);
        end
    endtask

    initial begin
        rst_pix = 1'b1;
        de      = 1'b0;
        din     = 8'h00;
        ctrl    = 2'b00;

        phase = "reset";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hAA, 2'b00, 1'b0, 10'h000, 0);

        phase = "ctrl";
        step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);
        step(1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 10'h0AB, 0);
        step(1'b0, 1'b0, 8'h00, 2'b10, 1'b1, 10'h154, 0);
        step(1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 10'h2AB, 0);

        phase = "disp";
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 10'h000, 0);
        step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8);
        step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF, 2);
        step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -6);

        phase = "xnor";
        step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);
        step(1'b0, 1'b1, 8'hFF, 2'b00, 1'b1, 10'h200, -8);

        phase = "degap";
        step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);
        step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8);
        step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);
        step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8);

        phase = "midrst";
        step(1'b0, 1'b1, 8'h3C, 2'b00, 1'b0, 10'h000, 0);
        step(1'b0, 1'b1, 8'h55, 2'b00, 1'b0, 10'h000, 0);
        step(1'b1, 1'b1, 8'h77, 2'b00, 1'b0, 10'h000, 0);
        step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8);
        step(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF, 2);

        phase = "rand";
        for (int i = 0; i < 10000; i++) begin
            logic       r;
            logic       d_e;
            logic [7:0] d;
            logic [1:0] c;
            r   = ($urandom_range(0, 499) == 0);
            d_e = ($urandom_range(0, 3) != 0);
            d   = 8'($urandom);
            c   = 2'($urandom);
            step(r, d_e, d, c, 1'b0, 10'h000, 0);
        end

        phase = "drain";
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 10'h000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
